// File: rtl/key_scan_multi.sv
// key_scan_multi: per-channel sync, debounce and press/release/long/repeat classification of NUM_KEYS buttons.
// Latency: key_down/key_up DEBOUNCE_CYCLES+2 edges after the first active/inactive sample; all pulses registered.
// Backpressure: none; every channel runs freely and pulses are single-cycle. Optional KEY_REPEAT_EN builds auto-repeat.
module key_scan_multi #(
  parameter int NUM_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES   = 100_000,
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES     = 10_000_000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_up,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_toggle
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int LONG_W = $clog2(LONG_PRESS_CYCLES);
  localparam int REP_W  = $clog2(REPEAT_CYCLES);
  // One hold counter serves both the long-press and repeat phases.
  localparam int HOLD_W = (LONG_W > REP_W) ? LONG_W : REP_W;
  // Pin level of a released key; synchroniser flops reset here.
  localparam logic INACTIVE = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PH_LONG   = 2'd0,
    PH_REPEAT = 2'd1,
    PH_DONE   = 2'd2
  } phase_e;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    logic              sync1_q, sync2_q;
    logic              active;
    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              down_q, down_d;
    logic              up_q, up_d;
    logic              long_q, long_d;
    logic              pressed_q, pressed_d;
    logic              toggle_q, toggle_d;
`ifdef KEY_REPEAT_EN
    logic              rep_q, rep_d;
`endif

    // Two-flop synchroniser for the raw pin, parked at the released level in reset.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sync1_q <= INACTIVE;
        sync2_q <= INACTIVE;
      end else begin
        sync1_q <= key_in[i];
        sync2_q <= sync1_q;
      end
    end

    assign active = sync2_q ^ INACTIVE;

    // Debounce FSM, hold counter and registered pulse/level generation.
    always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      deb_cnt_d  = deb_cnt_q;
      hold_cnt_d = hold_cnt_q;
      down_d     = 1'b0;
      up_d       = 1'b0;
      long_d     = 1'b0;
      toggle_d   = toggle_q;
`ifdef KEY_REPEAT_EN
      rep_d      = 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (active) begin
            state_d   = PRESS_DEB;
            deb_cnt_d = '0;
          end
        end
        PRESS_DEB: begin
          if (!active) begin
            state_d = IDLE;
          end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            state_d    = HELD;
            down_d     = 1'b1;
            toggle_d   = ~toggle_q;
            hold_cnt_d = '0;
            phase_d    = PH_LONG;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!active) begin
            state_d   = REL_DEB;
            deb_cnt_d = '0;
          end else begin
            case (phase_q)
              PH_LONG: begin
                if (hold_cnt_q == HOLD_W'(LONG_PRESS_CYCLES - 1)) begin
                  long_d     = 1'b1;
                  hold_cnt_d = '0;
`ifdef KEY_REPEAT_EN
                  phase_d    = PH_REPEAT;
`else
                  phase_d    = PH_DONE;
`endif
                end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
                end
              end
`ifdef KEY_REPEAT_EN
              PH_REPEAT: begin
                if (hold_cnt_q == HOLD_W'(REPEAT_CYCLES - 1)) begin
                  rep_d      = 1'b1;
                  hold_cnt_d = '0;
                end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
                end
              end
`endif
              default: begin
                hold_cnt_d = hold_cnt_q;
              end
            endcase
          end
        end
        REL_DEB: begin
          // Hold counter and phase stay frozen so a short glitch only delays long/repeat.
          if (active) begin
            state_d = HELD;
          end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            state_d = IDLE;
            up_d    = 1'b1;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      pressed_d = (state_d == HELD) || (state_d == REL_DEB);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q    <= IDLE;
        phase_q    <= PH_LONG;
        deb_cnt_q  <= '0;
        hold_cnt_q <= '0;
        down_q     <= 1'b0;
        up_q       <= 1'b0;
        long_q     <= 1'b0;
        pressed_q  <= 1'b0;
        toggle_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
        rep_q      <= 1'b0;
`endif
      end else begin
        state_q    <= state_d;
        phase_q    <= phase_d;
        deb_cnt_q  <= deb_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        down_q     <= down_d;
        up_q       <= up_d;
        long_q     <= long_d;
        pressed_q  <= pressed_d;
        toggle_q   <= toggle_d;
`ifdef KEY_REPEAT_EN
        rep_q      <= rep_d;
`endif
      end
    end

    assign key_down[i]    = down_q;
    assign key_up[i]      = up_q;
    assign key_long[i]    = long_q;
    assign key_pressed[i] = pressed_q;
    assign key_toggle[i]  = toggle_q;
`ifdef KEY_REPEAT_EN
    assign key_repeat[i]  = rep_q;
`endif
  end

`ifndef KEY_REPEAT_EN
  assign key_repeat = '0;
`endif

endmodule

// File: tb/tb_key_scan_multi.sv
// Bench for key_scan_multi: table of press scenarios plus hand-written bounce, glitch and reset sequences.
// Expected pulse events are queued with their edge number and matched against the DUT every falling edge.
module tb_key_scan_multi;
  localparam int NK    = 4;
  localparam int DEB   = 8;
  localparam int LONGC = 32;
  localparam int REP   = 10;
`ifdef KEY_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_down, key_up, key_long, key_repeat, key_pressed, key_toggle;

  key_scan_multi #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONGC),
    .REPEAT_CYCLES(REP), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rstn(rstn), .key_in(key_in),
    .key_down(key_down), .key_up(key_up), .key_long(key_long),
    .key_repeat(key_repeat), .key_pressed(key_pressed), .key_toggle(key_toggle)
  );

  always #5 clk = ~clk;

  // Edge number: value after the rising edge that produced the current outputs.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int ch;
    int kind;  // 0 down, 1 up, 2 long, 3 repeat
  } ev_t;

  typedef struct {
    logic [NK-1:0] mask;
    int            low_len;
    int            down_off;
    int            long_off;  // -1: no long pulse expected
    int            nrep;      // repeat pulses when repeat is built
    int            up_off;
  } vec_t;

  ev_t           exp_q[$];
  int            tests = 0;
  int            fails = 0;
  logic [NK-1:0] m_pressed = '0;
  logic [NK-1:0] m_toggle  = '0;
  vec_t          tbl[5];

  function automatic void push_ev(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    exp_q.push_back(e);
  endfunction

  // Scoreboard: compare pulses whenever any are expected or seen; compare levels every cycle.
  always @(negedge clk) begin : mon
    logic [NK-1:0] e_dn, e_up, e_lg, e_rp;
    if (!rstn) begin
      m_pressed = '0;
      m_toggle  = '0;
      exp_q.delete();
    end else begin
      e_dn = '0; e_up = '0; e_lg = '0; e_rp = '0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc == cyc) begin
          case (exp_q[i].kind)
            0:       e_dn[exp_q[i].ch] = 1'b1;
            1:       e_up[exp_q[i].ch] = 1'b1;
            2:       e_lg[exp_q[i].ch] = 1'b1;
            default: e_rp[exp_q[i].ch] = 1'b1;
          endcase
          exp_q.delete(i);
        end
      end
      if ({e_dn, e_up, e_lg, e_rp} != '0 ||
          {key_down, key_up, key_long, key_repeat} != '0) begin
        tests++;
        if ({key_down, key_up, key_long, key_repeat} != {e_dn, e_up, e_lg, e_rp}) begin
          fails++;
          $display("FAIL pulses edge %0d: got dn=%b up=%b lg=%b rp=%b, want dn=%b up=%b lg=%b rp=%b",
                   cyc, key_down, key_up, key_long, key_repeat, e_dn, e_up, e_lg, e_rp);
        end
      end
      m_pressed = (m_pressed | e_dn) & ~e_up;
      m_toggle  = m_toggle ^ e_dn;
      tests++;
      if ({key_pressed, key_toggle} != {m_pressed, m_toggle}) begin
        fails++;
        $display("FAIL levels edge %0d: got pressed=%b toggle=%b, want pressed=%b toggle=%b",
                 cyc, key_pressed, key_toggle, m_pressed, m_toggle);
      end
    end
  end

  task automatic check_all_zero(input string name);
    tests++;
    if ({key_down, key_up, key_long, key_repeat, key_pressed, key_toggle} != '0) begin
      fails++;
      $display("FAIL %s: got dn=%b up=%b lg=%b rp=%b pr=%b tg=%b, want all 0",
               name, key_down, key_up, key_long, key_repeat, key_pressed, key_toggle);
    end
  endtask

  // Press the masked keys for low_len edges starting at the next edge, queueing the expected pulses.
  task automatic run_vec(input vec_t v);
    int t0, nrep;
    t0   = cyc + 1;
    nrep = REP_ON ? v.nrep : 0;
    for (int ch = 0; ch < NK; ch++) begin
      if (v.mask[ch]) begin
        push_ev(t0 + v.down_off, ch, 0);
        if (v.long_off >= 0) begin
          push_ev(t0 + v.long_off, ch, 2);
          for (int k = 1; k <= nrep; k++) push_ev(t0 + v.long_off + REP * k, ch, 3);
        end
        push_ev(t0 + v.low_len + v.up_off, ch, 1);
      end
    end
    key_in = ~v.mask;
    repeat (v.low_len) @(negedge clk);
    key_in = '1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int c;
    tbl[0] = '{mask: 4'b0001, low_len: 20, down_off: 10, long_off: -1, nrep: 0, up_off: 10};
    tbl[1] = '{mask: 4'b1001, low_len: 20, down_off: 10, long_off: -1, nrep: 0, up_off: 10};
    tbl[2] = '{mask: 4'b0001, low_len: 70, down_off: 10, long_off: 42, nrep: 2, up_off: 10};
    tbl[3] = '{mask: 4'b0100, low_len: 45, down_off: 10, long_off: 42, nrep: 0, up_off: 10};
    tbl[4] = '{mask: 4'b0110, low_len: 12, down_off: 10, long_off: -1, nrep: 0, up_off: 10};

    rstn   = 1'b0;
    key_in = '1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("idle_after_reset");

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // Bounce on key 0: 5 low, 2 high, then low; one key_down 10 edges after the final falling sample.
    c = cyc;
    key_in = 4'b1110;
    repeat (5) @(negedge clk);
    key_in = '1;
    repeat (2) @(negedge clk);
    key_in = 4'b1110;
    push_ev(c + 8 + 10, 0, 0);
    repeat (20) @(negedge clk);
    key_in = '1;
    push_ev(c + 28 + 10, 0, 1);
    repeat (20) @(negedge clk);

    // 3-cycle release glitch on key 1 while held: no key_up, no second key_down.
    c = cyc;
    key_in = 4'b1101;
    push_ev(c + 1 + 10, 1, 0);
    repeat (15) @(negedge clk);
    key_in = '1;
    repeat (3) @(negedge clk);
    key_in = 4'b1101;
    repeat (10) @(negedge clk);
    key_in = '1;
    push_ev(c + 1 + 28 + 10, 1, 1);
    repeat (20) @(negedge clk);

    // Reset while key 0 is held, then release reset with the key still down.
    c = cyc;
    key_in = 4'b1110;
    push_ev(c + 1 + 10, 0, 0);
    repeat (15) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_all_zero("reset_mid_held");
    repeat (3) @(negedge clk);
    c = cyc;
    rstn = 1'b1;
    push_ev(c + 1 + 10, 0, 0);
    repeat (12) @(negedge clk);
    tests++;
    if (key_toggle[0] !== 1'b1) begin
      fails++;
      $display("FAIL toggle_after_reset: got %b, want 1", key_toggle[0]);
    end
    key_in = '1;
    push_ev(cyc + 1 + 10, 0, 1);
    repeat (20) @(negedge clk);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_events: got %0d expected pulses never seen, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
